host_wire_insn_bridge: RTL and testbench
========================================

Name: host_wire_insn_bridge

Overview:
- Converts level-based host wire-in writes into a clean valid/ready instruction stream for the emulator top.
- Host writes two 16-bit halves, then toggles a sequence bit. The bridge captures the pair, queues it in a small FIFO and echoes the sequence bit as an ack on a wire-out.
- Sits between the host wire-in/wire-out endpoints and the insns port of the emulator top, in the host clock domain.

Parameters:
- DATA_W, 16, width of each instruction half.
- DEPTH, 4, FIFO entries; power of two, >= 2.
- LVL_W, $clog2(DEPTH+1), width of the level count.

Ports:
- clock  in  1  host-side clock; all logic on rising edge.
- reset  in  1  synchronous, active-high; sampled on the rising edge of clock.
- wire_seq  in  1  host toggle; each change = one new transaction.
- wire_flush  in  1  level; while 1, FIFO cleared and pending transaction discarded.
- wire_bits_0  in  DATA_W  instruction half 0.
- wire_bits_1  in  DATA_W  instruction half 1.
- wire_ack  out  1  equals last accepted (or flushed) wire_seq value.
- wire_level  out  LVL_W  current FIFO occupancy.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer ready.
- out_bits_0  out  DATA_W  head half 0.
- out_bits_1  out  DATA_W  head half 1.

Behaviour:
- Reset values: wire_ack=0, wire_level=0, out_valid=0, out_bits_*=0 (head RAM contents ignored while empty), seq_q=0, state=IDLE.
- The host must also return wire_seq to 0 across a reset.
- Edge detect: a new transaction is wire_seq != seq_q.
- State IDLE, new transaction, FIFO not full:
  - Push {wire_bits_1, wire_bits_0}.
  - seq_q <= wire_seq and wire_ack <= wire_seq.
  - Ack visible 1 cycle after wire_seq changes.
- State IDLE, new transaction, FIFO full:
  - Latch both halves into a hold register and go to PEND.
  - wire_ack is unchanged.
- State PEND:
  - On the first cycle with count < DEPTH, push the hold register, update seq_q/wire_ack and return to IDLE.
  - wire_seq changes while in PEND are ignored until the return to IDLE. The host protocol forbids toggling before the ack.
- Full test uses the registered count only. A pop in the same cycle does not free space for a push that cycle; the push happens the next cycle.
- FIFO is first-word fall-through:
  - out_valid = (count != 0).
  - out_bits_* driven from the head entry, combinationally from the registered read pointer.
  - Pop on out_valid && out_ready.
- Simultaneous push and pop: count unchanged, both pointers advance. Pointers wrap modulo DEPTH.
- wire_level = count, registered; updates the cycle after push/pop.
- Flush (highest priority after reset), every cycle wire_flush=1:
  - count=0, pointers=0, state=IDLE.
  - seq_q <= wire_seq and wire_ack <= wire_seq: any pending transaction is acked and discarded.
  - No pushes or pops.
- out_bits_* must hold stable while out_valid=1 and out_ready=0.

Optional Feature:
- Macro: HOST_WIRE_INSN_BRIDGE_CNT_EN.
- Defined: adds output port xfer_count (32 bits) counting accepted pushes (not flushed ones). Reset and flush clear it to 0; it wraps at 2^32.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Basic transfer: bits_0=0x1234, bits_1=0xABCD, toggle seq 0->1, out_ready=1 -> wire_ack=1 one cycle later; out_valid=1 with out_bits=0xABCD/0x1234 one cycle after capture; popped; wire_level returns to 0.
- Fill and backpressure: out_ready=0, five toggles each waiting for ack -> acks 1..4 arrive, wire_level=4, fifth ack withheld (PEND). Raise out_ready for one cycle -> fifth pushed and acked the following cycle; order preserved, values 0..4 in sequence.
- Simultaneous push/pop: level=2, out_ready=1 and a new toggle in the same cycle -> level stays 2; head advances by one; new entry lands at the tail.
- Flush while PEND: FIFO full, toggle pending, assert wire_flush 1 cycle -> level=0, out_valid=0, wire_ack equals wire_seq, pending data never appears at the output.
- Reset mid-operation: level=3, assert reset with wire_seq driven to 0 -> all outputs at reset values next cycle; a new 0->1 toggle is accepted normally.
- CNT_EN build: 7 accepted transfers, then flush, then 2 more -> xfer_count reads 7 before the flush, 0 after it, and 2 at the end.

Source files
------------

// File: rtl/host_wire_insn_bridge.sv
// Host wire-in to valid/ready instruction bridge with a small FWFT FIFO.
// Define HOST_WIRE_INSN_BRIDGE_CNT_EN to add the xfer_count output.
module host_wire_insn_bridge #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4,
  parameter int LVL_W  = $clog2(DEPTH + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wire_seq,
  input  logic              wire_flush,
  input  logic [DATA_W-1:0] wire_bits_0,
  input  logic [DATA_W-1:0] wire_bits_1,
  output logic              wire_ack,
  output logic [LVL_W-1:0]  wire_level,
  output logic              out_valid,
  input  logic              out_ready,
`ifdef HOST_WIRE_INSN_BRIDGE_CNT_EN
  output logic [31:0]       xfer_count,
`endif
  output logic [DATA_W-1:0] out_bits_0,
  output logic [DATA_W-1:0] out_bits_1
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic {
    IDLE,
    PEND
  } state_t;

  state_t              state;
  logic                seq_q;
  logic                hold_seq;
  logic [2*DATA_W-1:0] hold;
  logic [2*DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]    rptr;
  logic [PTR_W-1:0]    wptr;
  logic [LVL_W-1:0]    count;

  logic                full;
  logic                new_txn;
  logic                push;
  logic                pop;
  logic [2*DATA_W-1:0] push_data;
  logic [2*DATA_W-1:0] head;

  // Full test uses only the registered count; a same-cycle pop frees nothing.
  always_comb begin
    full      = (count == LVL_W'(DEPTH));
    new_txn   = (wire_seq != seq_q);
    pop       = (count != '0) && out_ready;
    push      = 1'b0;
    push_data = hold;
    unique case (state)
      IDLE: begin
        if (new_txn && !full) begin
          push      = 1'b1;
          push_data = {wire_bits_1, wire_bits_0};
        end
      end
      PEND: begin
        if (!full) push = 1'b1;
      end
      default: push = 1'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      seq_q    <= 1'b0;
      wire_ack <= 1'b0;
      hold     <= '0;
      hold_seq <= 1'b0;
      rptr     <= '0;
      wptr     <= '0;
      count    <= '0;
    end else if (wire_flush) begin
      state    <= IDLE;
      seq_q    <= wire_seq;
      wire_ack <= wire_seq;
      rptr     <= '0;
      wptr     <= '0;
      count    <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      count <= count + LVL_W'(push) - LVL_W'(pop);
      unique case (state)
        IDLE: begin
          if (new_txn && !full) begin
            seq_q    <= wire_seq;
            wire_ack <= wire_seq;
          end else if (new_txn) begin
            hold     <= {wire_bits_1, wire_bits_0};
            hold_seq <= wire_seq;
            state    <= PEND;
          end
        end
        PEND: begin
          if (!full) begin
            seq_q    <= hold_seq;
            wire_ack <= hold_seq;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && !wire_flush && push) mem[wptr] <= push_data;
  end

`ifdef HOST_WIRE_INSN_BRIDGE_CNT_EN
  always_ff @(posedge clock) begin
    if (reset || wire_flush) xfer_count <= '0;
    else if (push)           xfer_count <= xfer_count + 32'd1;
  end
`endif

  assign head       = mem[rptr];
  assign wire_level = count;
  assign out_valid  = (count != '0);
  assign out_bits_0 = out_valid ? head[DATA_W-1:0] : '0;
  assign out_bits_1 = out_valid ? head[2*DATA_W-1:DATA_W] : '0;

endmodule

// File: tb/tb_host_wire_insn_bridge.sv
// Directed vector bench for host_wire_insn_bridge.
// Covers transfer, fill/PEND, push+pop, flush, reset and the counter build.
module tb_host_wire_insn_bridge;

  logic        clock = 1'b0;
  logic        reset;
  logic        wire_seq;
  logic        wire_flush;
  logic [15:0] wire_bits_0;
  logic [15:0] wire_bits_1;
  logic        wire_ack;
  logic [2:0]  wire_level;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_bits_0;
  logic [15:0] out_bits_1;
`ifdef HOST_WIRE_INSN_BRIDGE_CNT_EN
  logic [31:0] xfer_count;
`endif

  int checks = 0;
  int fails  = 0;

  always #5 clock = ~clock;

  host_wire_insn_bridge dut (
    .clock       (clock),
    .reset       (reset),
    .wire_seq    (wire_seq),
    .wire_flush  (wire_flush),
    .wire_bits_0 (wire_bits_0),
    .wire_bits_1 (wire_bits_1),
    .wire_ack    (wire_ack),
    .wire_level  (wire_level),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
`ifdef HOST_WIRE_INSN_BRIDGE_CNT_EN
    .xfer_count  (xfer_count),
`endif
    .out_bits_0  (out_bits_0),
    .out_bits_1  (out_bits_1)
  );

  typedef struct {
    logic        seq;
    logic        rdy;
    logic [15:0] b0;
    logic [15:0] b1;
    logic        ack;
    logic [2:0]  lvl;
    logic        vld;
    logic [15:0] e0;
    logic [15:0] e1;
  } vec_t;

  vec_t vt[14];

  function automatic vec_t mk(bit s, bit r, int b0, int b1, bit a,
                              int l, bit v, int e0, int e1);
    vec_t m;
    m.seq = s;
    m.rdy = r;
    m.b0  = b0[15:0];
    m.b1  = b1[15:0];
    m.ack = a;
    m.lvl = l[2:0];
    m.vld = v;
    m.e0  = e0[15:0];
    m.e1  = e1[15:0];
    return m;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_out(string tag, logic a, int l, logic v, int e0, int e1);
    chk({tag, ".ack"}, 32'(wire_ack), 32'(a));
    chk({tag, ".lvl"}, 32'(wire_level), 32'(l));
    chk({tag, ".vld"}, 32'(out_valid), 32'(v));
    chk({tag, ".b0"}, 32'(out_bits_0), 32'(e0));
    chk({tag, ".b1"}, 32'(out_bits_1), 32'(e1));
  endtask

  initial begin
    // basic transfer, then pop
    vt[0]  = mk(1, 1, 'h1234, 'hABCD, 1, 1, 1, 'h1234, 'hABCD);
    vt[1]  = mk(1, 1, 'h1234, 'hABCD, 1, 0, 0, 0, 0);
    // fill with backpressure, fifth goes PEND
    vt[2]  = mk(0, 0, 0, 'h100, 0, 1, 1, 0, 'h100);
    vt[3]  = mk(1, 0, 1, 'h101, 1, 2, 1, 0, 'h100);
    vt[4]  = mk(0, 0, 2, 'h102, 0, 3, 1, 0, 'h100);
    vt[5]  = mk(1, 0, 3, 'h103, 1, 4, 1, 0, 'h100);
    vt[6]  = mk(0, 0, 4, 'h104, 1, 4, 1, 0, 'h100);
    vt[7]  = mk(0, 1, 4, 'h104, 1, 3, 1, 1, 'h101);
    vt[8]  = mk(0, 0, 4, 'h104, 0, 4, 1, 1, 'h101);
    vt[9]  = mk(0, 1, 4, 'h104, 0, 3, 1, 2, 'h102);
    vt[10] = mk(0, 1, 4, 'h104, 0, 2, 1, 3, 'h103);
    // simultaneous push and pop at level 2
    vt[11] = mk(1, 1, 5, 'h105, 1, 2, 1, 4, 'h104);
    vt[12] = mk(1, 1, 5, 'h105, 1, 1, 1, 5, 'h105);
    vt[13] = mk(1, 1, 5, 'h105, 1, 0, 0, 0, 0);

    reset       = 1'b1;
    wire_seq    = 1'b0;
    wire_flush  = 1'b0;
    wire_bits_0 = '0;
    wire_bits_1 = '0;
    out_ready   = 1'b0;
    cyc();
    cyc();
    chk_out("reset", 1'b0, 0, 1'b0, 0, 0);
    reset = 1'b0;

    for (int i = 0; i < 14; i++) begin
      wire_seq    = vt[i].seq;
      out_ready   = vt[i].rdy;
      wire_bits_0 = vt[i].b0;
      wire_bits_1 = vt[i].b1;
      cyc();
      chk_out($sformatf("v%0d", i), vt[i].ack, int'(vt[i].lvl),
              vt[i].vld, int'(vt[i].e0), int'(vt[i].e1));
    end

    // flush while PEND
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wire_seq    = ~wire_seq;
      wire_bits_0 = 16'(16'h10 + i);
      wire_bits_1 = 16'(16'h20 + i);
      cyc();
      chk($sformatf("fill%0d.ack", i), 32'(wire_ack), 32'(wire_seq));
    end
    wire_seq    = 1'b0;
    wire_bits_0 = 16'hDEAD;
    wire_bits_1 = 16'hDEAD;
    cyc();
    cyc();
    chk("pend.ack", 32'(wire_ack), 32'd1);
    chk("pend.lvl", 32'(wire_level), 32'd4);
    chk("pend.head", 32'(out_bits_0), 32'h10);
    wire_flush = 1'b1;
    cyc();
    wire_flush = 1'b0;
    chk("flush.ack", 32'(wire_ack), 32'd0);
    chk("flush.lvl", 32'(wire_level), 32'd0);
    chk("flush.vld", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk($sformatf("postflush%0d.vld", i), 32'(out_valid), 32'd0);
    end
    out_ready   = 1'b0;
    wire_seq    = 1'b1;
    wire_bits_0 = 16'h0055;
    wire_bits_1 = 16'h5555;
    cyc();
    chk_out("afterflush", 1'b1, 1, 1'b1, 'h55, 'h5555);

    // reset mid-operation at level 3
    wire_seq    = 1'b0;
    wire_bits_0 = 16'h0056;
    cyc();
    wire_seq    = 1'b1;
    wire_bits_0 = 16'h0057;
    cyc();
    chk("prereset.lvl", 32'(wire_level), 32'd3);
    reset    = 1'b1;
    wire_seq = 1'b0;
    cyc();
    chk_out("midreset", 1'b0, 0, 1'b0, 0, 0);
    reset       = 1'b0;
    wire_seq    = 1'b1;
    wire_bits_0 = 16'h0077;
    wire_bits_1 = 16'h7777;
    cyc();
    chk_out("afterreset", 1'b1, 1, 1'b1, 'h77, 'h7777);

`ifdef HOST_WIRE_INSN_BRIDGE_CNT_EN
    reset    = 1'b1;
    wire_seq = 1'b0;
    cyc();
    reset     = 1'b0;
    out_ready = 1'b1;
    chk("cnt.reset", xfer_count, 32'd0);
    for (int i = 0; i < 7; i++) begin
      wire_seq = ~wire_seq;
      cyc();
    end
    chk("cnt.seven", xfer_count, 32'd7);
    wire_flush = 1'b1;
    cyc();
    wire_flush = 1'b0;
    chk("cnt.flush", xfer_count, 32'd0);
    for (int i = 0; i < 2; i++) begin
      wire_seq = ~wire_seq;
      cyc();
    end
    chk("cnt.two", xfer_count, 32'd2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", checks, fails);
    $finish;
  end

endmodule
